game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Parametrised master sequencer for the tile game. It is the successor of the single-life master control. It drives the go/done handshakes to the screen-reset, input-check, correct/incorrect feedback, edge-handling, draw and row-wait engines. It adds a lives counter, score-driven speed levels and a configurable lane count and edge row.

Parameters:
LANES, 3, width of the bottom (edge) row occupancy mask
OFFSET_W, 6, width of the scroll offset input
EDGE_OFFSET, 40, offset value at which the bottom row reaches the edge
LIVES, 3, misses tolerated per game (1..15)
SPEEDUP_EVERY, 8, correct hits per speed-level increment (>=1)
MAX_SPEED, 7, saturating ceiling of speed_level (<=15)

Ports:
clock  in  1  system clock
resetn  in  1  synchronous active-low reset
startn  in  1  active-low start request
reset_screen_done  in  1  screen clear finished
check_input_done  in  1  input check finished; correct/incorrect valid this cycle
correct  in  1  qualified by check_input_done
incorrect  in  1  qualified by check_input_done
correct_done  in  1  correct-feedback engine finished
incorrect_input_done  in  1  incorrect-feedback engine finished
colour_line_done  in  1  missed-line highlight finished
draw_done  in  1  frame draw finished
wait_done  in  1  row timer expired
offset  in  OFFSET_W  current scroll offset
edge_row  in  LANES  tiles remaining in the edge row (1 = unhit)
reset_screen_go, check_input_go, correct_go, incorrect_input_go, edge_go, colour_line_go, draw_go, wait_go, offset_increase  out  1 each  engine enables
game_over  out  1  sticky end-of-game flag
lives_left  out  4  remaining lives
speed_level  out  4  row-timer speed select for the wait engine
current_state  out  4  encoded state, for debug and HUD

Behaviour:
- Reset (resetn low at clock edge): state IDLE; all go outputs 0; game_over 0; lives_left LIVES; speed_level 0; hit counter 0.
- Go outputs are a Moore decode of the current state. Exactly one is high per state; none in IDLE, DETECT_EDGE, EDGE_CHECK or GAME_OVER.
- States and mapping:
  - IDLE
  - RESET_SCREEN (reset_screen_go)
  - CHECK_INPUT (check_input_go)
  - CORRECT (correct_go)
  - INCORRECT (incorrect_input_go)
  - DETECT_EDGE
  - EDGE_CHECK
  - EDGE_ADVANCE (edge_go)
  - EDGE_FAIL (colour_line_go)
  - DRAW (draw_go)
  - WAIT (wait_go)
  - NEXT_ROW (offset_increase)
  - GAME_OVER
- Transitions:
  - IDLE -> RESET_SCREEN when startn is low. On this edge: lives reload to LIVES, speed_level and hit counter clear, game_over clears.
  - RESET_SCREEN -> CHECK_INPUT on reset_screen_done.
  - CHECK_INPUT on check_input_done: correct -> CORRECT; else incorrect -> INCORRECT; else -> DETECT_EDGE. Correct wins if both are high.
  - CORRECT -> DETECT_EDGE on correct_done. The hit counter increments on entry.
  - When the hit counter reaches SPEEDUP_EVERY it returns to 0 and speed_level increments, saturating at MAX_SPEED.
  - INCORRECT: lives_left decrements on entry, saturating at 0. On incorrect_input_done: lives_left==0 -> GAME_OVER, else -> DETECT_EDGE.
  - DETECT_EDGE -> EDGE_CHECK if offset==EDGE_OFFSET, else -> DRAW. One cycle.
  - EDGE_CHECK -> EDGE_ADVANCE if edge_row is all zero; else -> EDGE_FAIL with lives_left decremented on that edge. One cycle.
  - EDGE_FAIL on colour_line_done: lives_left==0 -> GAME_OVER, else -> EDGE_ADVANCE. The row is consumed so play continues.
  - EDGE_ADVANCE -> DRAW. One cycle.
  - DRAW -> WAIT on draw_done.
  - WAIT -> NEXT_ROW on wait_done.
  - NEXT_ROW -> CHECK_INPUT. One cycle.
  - GAME_OVER -> IDLE after one cycle; game_over is set on entry and held until the next start.
- A done input arriving in any state other than its owner is ignored.
- Unused state encodings return to IDLE.
- Reset mid-game aborts immediately; no go is asserted the cycle after the reset edge.
- Latency: one clock from a qualifying done to the next go.

Optional Feature:
GAME_SEQUENCER_PAUSE_EN:
- Defined: adds input pausen (active low) and state PAUSED.
- In WAIT with pausen low, the FSM moves to PAUSED instead of honouring wait_done. No go is asserted in PAUSED.
- PAUSED returns to WAIT when pausen goes high. The row timer restarts from zero.
- Not defined: no port, no state; WAIT behaves as above.

Decomposition:
- Package game_seq_pkg holds:
  - the state encoding constants (4-bit);
  - the LIVES/SPEED width constant (4).
- Sub-module game_seq_stats holds the lives counter, hit counter and speed_level. It is driven by load/dec/hit strobes from the FSM.

Test Plan:
- Start, then 8 correct hits (SPEEDUP_EVERY=8) -> speed_level goes 0→1 one cycle after the 8th CORRECT entry; lives_left stays 3.
- Three incorrect inputs -> lives_left 2, then 1, then 0; after the third incorrect_input_done, GAME_OVER then IDLE; game_over=1 until startn goes low.
- offset=40 with edge_row=3'b010 -> EDGE_FAIL, colour_line_go=1, lives 3→2; on colour_line_done -> EDGE_ADVANCE (edge_go=1 for one cycle) -> DRAW.
- check_input_done with correct=1 and incorrect=1 -> CORRECT taken; lives unchanged.
- 20 correct hits with MAX_SPEED=1, SPEEDUP_EVERY=2 -> speed_level saturates at 1.
- resetn low during DRAW -> next cycle current_state=IDLE, all go outputs 0, lives_left=3.

Source files
------------

// File: rtl/game_seq_pkg.sv
// Shared types for the tile-game master sequencer.
// State PAUSED exists only when GAME_SEQUENCER_PAUSE_EN is defined.
package game_seq_pkg;

  localparam int STAT_W = 4;
  localparam int GO_W   = 9;

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_RESET_SCREEN = 4'd1,
    S_CHECK_INPUT  = 4'd2,
    S_CORRECT      = 4'd3,
    S_INCORRECT    = 4'd4,
    S_DETECT_EDGE  = 4'd5,
    S_EDGE_CHECK   = 4'd6,
    S_EDGE_ADVANCE = 4'd7,
    S_EDGE_FAIL    = 4'd8,
    S_DRAW         = 4'd9,
    S_WAIT         = 4'd10,
    S_NEXT_ROW     = 4'd11,
`ifdef GAME_SEQUENCER_PAUSE_EN
    S_GAME_OVER    = 4'd12,
    S_PAUSED       = 4'd13
`else
    S_GAME_OVER    = 4'd12
`endif
  } state_e;

  // Go bus order, MSB first: reset_screen, check_input, correct,
  // incorrect_input, edge, colour_line, draw, wait, offset_increase.
  function automatic logic [GO_W-1:0] go_decode(state_e s);
    logic [GO_W-1:0] g;
    g = '0;
    case (s)
      S_RESET_SCREEN: g[8] = 1'b1;
      S_CHECK_INPUT:  g[7] = 1'b1;
      S_CORRECT:      g[6] = 1'b1;
      S_INCORRECT:    g[5] = 1'b1;
      S_EDGE_ADVANCE: g[4] = 1'b1;
      S_EDGE_FAIL:    g[3] = 1'b1;
      S_DRAW:         g[2] = 1'b1;
      S_WAIT:         g[1] = 1'b1;
      S_NEXT_ROW:     g[0] = 1'b1;
      default:        g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/game_seq_stats.sv
// Lives, hit counter and speed level for the game sequencer.
// Driven by load/dec/hit strobes; load has priority.
module game_seq_stats
  import game_seq_pkg::*;
#(
  parameter int LIVES         = 3,
  parameter int SPEEDUP_EVERY = 8,
  parameter int MAX_SPEED     = 7
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic              dec,
  input  logic              hit,
  output logic [STAT_W-1:0] lives_left,
  output logic [STAT_W-1:0] speed_level
);

  localparam int HIT_W = $clog2(SPEEDUP_EVERY + 1);
  localparam logic [HIT_W-1:0] HIT_TOP = HIT_W'(SPEEDUP_EVERY - 1);
  localparam logic [STAT_W-1:0] LIVES_V = STAT_W'(LIVES);
  localparam logic [STAT_W-1:0] MAX_V = STAT_W'(MAX_SPEED);

  logic [STAT_W-1:0] lives_q, lives_d;
  logic [STAT_W-1:0] speed_q, speed_d;
  logic [HIT_W-1:0]  hits_q, hits_d;

  always_comb begin
    lives_d = lives_q;
    speed_d = speed_q;
    hits_d  = hits_q;
    if (load) begin
      lives_d = LIVES_V;
      speed_d = '0;
      hits_d  = '0;
    end else begin
      if (dec && lives_q != '0)
        lives_d = lives_q - STAT_W'(1);
      // The hit that completes a group wraps the counter and bumps speed.
      if (hit) begin
        if (hits_q >= HIT_TOP) begin
          hits_d = '0;
          if (speed_q < MAX_V)
            speed_d = speed_q + STAT_W'(1);
        end else begin
          hits_d = hits_q + HIT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      lives_q <= LIVES_V;
      speed_q <= '0;
      hits_q  <= '0;
    end else begin
      lives_q <= lives_d;
      speed_q <= speed_d;
      hits_q  <= hits_d;
    end
  end

  assign lives_left  = lives_q;
  assign speed_level = speed_q;

endmodule

// File: rtl/game_sequencer.sv
// Master sequencer for the tile game: lives, speed levels, edge row.
// Optional pause support under GAME_SEQUENCER_PAUSE_EN.
module game_sequencer
  import game_seq_pkg::*;
#(
  parameter int LANES         = 3,
  parameter int OFFSET_W      = 6,
  parameter int EDGE_OFFSET   = 40,
  parameter int LIVES         = 3,
  parameter int SPEEDUP_EVERY = 8,
  parameter int MAX_SPEED     = 7
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                startn,
`ifdef GAME_SEQUENCER_PAUSE_EN
  input  logic                pausen,
`endif
  input  logic                reset_screen_done,
  input  logic                check_input_done,
  input  logic                correct,
  input  logic                incorrect,
  input  logic                correct_done,
  input  logic                incorrect_input_done,
  input  logic                colour_line_done,
  input  logic                draw_done,
  input  logic                wait_done,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [LANES-1:0]    edge_row,
  output logic                reset_screen_go,
  output logic                check_input_go,
  output logic                correct_go,
  output logic                incorrect_input_go,
  output logic                edge_go,
  output logic                colour_line_go,
  output logic                draw_go,
  output logic                wait_go,
  output logic                offset_increase,
  output logic                game_over,
  output logic [3:0]          lives_left,
  output logic [3:0]          speed_level,
  output logic [3:0]          current_state
);

  localparam logic [OFFSET_W-1:0] EDGE_V = OFFSET_W'(EDGE_OFFSET);

  state_e          state_q, state_d;
  logic [GO_W-1:0] go_q, go_d;
  logic            game_over_q, game_over_d;
  logic            load, dec, hit;
  logic [STAT_W-1:0] lives;

  always_comb begin
    state_d     = state_q;
    game_over_d = game_over_q;
    load        = 1'b0;
    dec         = 1'b0;
    hit         = 1'b0;
    case (state_q)
      S_IDLE:
        if (!startn) begin
          state_d     = S_RESET_SCREEN;
          load        = 1'b1;
          game_over_d = 1'b0;
        end
      S_RESET_SCREEN:
        if (reset_screen_done) state_d = S_CHECK_INPUT;
      S_CHECK_INPUT:
        if (check_input_done) begin
          if (correct) begin
            state_d = S_CORRECT;
            hit     = 1'b1;
          end else if (incorrect) begin
            state_d = S_INCORRECT;
            dec     = 1'b1;
          end else begin
            state_d = S_DETECT_EDGE;
          end
        end
      S_CORRECT:
        if (correct_done) state_d = S_DETECT_EDGE;
      S_INCORRECT:
        if (incorrect_input_done)
          state_d = (lives == '0) ? S_GAME_OVER : S_DETECT_EDGE;
      S_DETECT_EDGE:
        state_d = (offset == EDGE_V) ? S_EDGE_CHECK : S_DRAW;
      S_EDGE_CHECK:
        if (edge_row == '0) begin
          state_d = S_EDGE_ADVANCE;
        end else begin
          state_d = S_EDGE_FAIL;
          dec     = 1'b1;
        end
      S_EDGE_FAIL:
        if (colour_line_done)
          state_d = (lives == '0) ? S_GAME_OVER : S_EDGE_ADVANCE;
      S_EDGE_ADVANCE:
        state_d = S_DRAW;
      S_DRAW:
        if (draw_done) state_d = S_WAIT;
`ifdef GAME_SEQUENCER_PAUSE_EN
      S_WAIT:
        if (!pausen)        state_d = S_PAUSED;
        else if (wait_done) state_d = S_NEXT_ROW;
      S_PAUSED:
        if (pausen) state_d = S_WAIT;
`else
      S_WAIT:
        if (wait_done) state_d = S_NEXT_ROW;
`endif
      S_NEXT_ROW:
        state_d = S_CHECK_INPUT;
      S_GAME_OVER:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
    if (state_d == S_GAME_OVER) game_over_d = 1'b1;
    // Outputs are registered from the next state so they track state_q.
    go_d = go_decode(state_d);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      go_q        <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      go_q        <= go_d;
      game_over_q <= game_over_d;
    end
  end

  game_seq_stats #(
    .LIVES         (LIVES),
    .SPEEDUP_EVERY (SPEEDUP_EVERY),
    .MAX_SPEED     (MAX_SPEED)
  ) u_stats (
    .clock       (clock),
    .resetn      (resetn),
    .load        (load),
    .dec         (dec),
    .hit         (hit),
    .lives_left  (lives),
    .speed_level (speed_level)
  );

  assign reset_screen_go    = go_q[8];
  assign check_input_go     = go_q[7];
  assign correct_go         = go_q[6];
  assign incorrect_input_go = go_q[5];
  assign edge_go            = go_q[4];
  assign colour_line_go     = go_q[3];
  assign draw_go            = go_q[2];
  assign wait_go            = go_q[1];
  assign offset_increase    = go_q[0];
  assign game_over          = game_over_q;
  assign lives_left         = lives;
  assign current_state      = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer; a second instance with
// SPEEDUP_EVERY=2, MAX_SPEED=1 runs in lockstep on the same inputs.
module tb_game_sequencer;
  import game_seq_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetn = 1'b0, startn = 1'b1;
`ifdef GAME_SEQUENCER_PAUSE_EN
  logic pausen = 1'b1;
`endif
  logic reset_screen_done = 0, check_input_done = 0;
  logic correct = 0, incorrect = 0, correct_done = 0;
  logic incorrect_input_done = 0, colour_line_done = 0;
  logic draw_done = 0, wait_done = 0;
  logic [5:0] offset = '0;
  logic [2:0] edge_row = '0;

  logic [8:0] go_a, go_b;
  logic       gover_a, gover_b;
  logic [3:0] lives_a, lives_b, speed_a, speed_b, cur_a, cur_b;

  localparam logic [8:0] G_NONE = 9'b000000000;
  localparam logic [8:0] G_RS   = 9'b100000000;
  localparam logic [8:0] G_CHK  = 9'b010000000;
  localparam logic [8:0] G_COR  = 9'b001000000;
  localparam logic [8:0] G_INC  = 9'b000100000;
  localparam logic [8:0] G_EDGE = 9'b000010000;
  localparam logic [8:0] G_COL  = 9'b000001000;
  localparam logic [8:0] G_DRAW = 9'b000000100;
  localparam logic [8:0] G_WAIT = 9'b000000010;
  localparam logic [8:0] G_NEXT = 9'b000000001;

  game_sequencer dut_a (
    .clock(clock), .resetn(resetn), .startn(startn),
`ifdef GAME_SEQUENCER_PAUSE_EN
    .pausen(pausen),
`endif
    .reset_screen_done(reset_screen_done),
    .check_input_done(check_input_done),
    .correct(correct), .incorrect(incorrect),
    .correct_done(correct_done),
    .incorrect_input_done(incorrect_input_done),
    .colour_line_done(colour_line_done),
    .draw_done(draw_done), .wait_done(wait_done),
    .offset(offset), .edge_row(edge_row),
    .reset_screen_go(go_a[8]), .check_input_go(go_a[7]),
    .correct_go(go_a[6]), .incorrect_input_go(go_a[5]),
    .edge_go(go_a[4]), .colour_line_go(go_a[3]),
    .draw_go(go_a[2]), .wait_go(go_a[1]),
    .offset_increase(go_a[0]),
    .game_over(gover_a), .lives_left(lives_a),
    .speed_level(speed_a), .current_state(cur_a)
  );

  game_sequencer #(.SPEEDUP_EVERY(2), .MAX_SPEED(1)) dut_b (
    .clock(clock), .resetn(resetn), .startn(startn),
`ifdef GAME_SEQUENCER_PAUSE_EN
    .pausen(pausen),
`endif
    .reset_screen_done(reset_screen_done),
    .check_input_done(check_input_done),
    .correct(correct), .incorrect(incorrect),
    .correct_done(correct_done),
    .incorrect_input_done(incorrect_input_done),
    .colour_line_done(colour_line_done),
    .draw_done(draw_done), .wait_done(wait_done),
    .offset(offset), .edge_row(edge_row),
    .reset_screen_go(go_b[8]), .check_input_go(go_b[7]),
    .correct_go(go_b[6]), .incorrect_input_go(go_b[5]),
    .edge_go(go_b[4]), .colour_line_go(go_b[3]),
    .draw_go(go_b[2]), .wait_go(go_b[1]),
    .offset_increase(go_b[0]),
    .game_over(gover_b), .lives_left(lives_b),
    .speed_level(speed_b), .current_state(cur_b)
  );

  int pass_cnt = 0;
  int total    = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_state(input string tag, input state_e s);
    for (int i = 0; i < 40 && cur_a != s; i++) tick();
    check(tag, cur_a, s);
  endtask

  task automatic row(input logic c, input logic i);
    wait_state("row_check", S_CHECK_INPUT);
    correct = c; incorrect = i; check_input_done = 1; tick();
    check_input_done = 0; correct = 0; incorrect = 0;
    if (c) begin
      correct_done = 1; tick(); correct_done = 0;
    end else if (i) begin
      incorrect_input_done = 1; tick(); incorrect_input_done = 0;
    end
    if (cur_a != S_GAME_OVER) begin
      wait_state("row_draw", S_DRAW);
      draw_done = 1; tick(); draw_done = 0;
      wait_state("row_wait", S_WAIT);
      wait_done = 1; tick(); wait_done = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    check("rst_state", cur_a, S_IDLE);
    check("rst_go", go_a, G_NONE);
    check("rst_lives", lives_a, 3);
    check("rst_speed", speed_a, 0);
    check("rst_gover", gover_a, 0);
    resetn = 1; tick();
    check("idle_hold", cur_a, S_IDLE);

    startn = 0; tick(); startn = 1;
    check("start_state", cur_a, S_RESET_SCREEN);
    check("start_go", go_a, G_RS);
    draw_done = 1; tick(); draw_done = 0;
    check("rs_ignore", cur_a, S_RESET_SCREEN);
    reset_screen_done = 1; tick(); reset_screen_done = 0;
    check("chk_state", cur_a, S_CHECK_INPUT);
    check("chk_go", go_a, G_CHK);

    // Both correct and incorrect: correct wins.
    correct = 1; incorrect = 1; check_input_done = 1; tick();
    check_input_done = 0; correct = 0; incorrect = 0;
    check("both_state", cur_a, S_CORRECT);
    check("both_go", go_a, G_COR);
    check("both_lives", lives_a, 3);
    correct_done = 1; tick(); correct_done = 0;
    check("det_state", cur_a, S_DETECT_EDGE);
    check("det_go", go_a, G_NONE);
    tick();
    check("draw_state", cur_a, S_DRAW);
    check("draw_go", go_a, G_DRAW);
    draw_done = 1; tick(); draw_done = 0;
    check("wait_go", go_a, G_WAIT);
    wait_done = 1; tick(); wait_done = 0;
    check("next_state", cur_a, S_NEXT_ROW);
    check("next_go", go_a, G_NEXT);

    for (int k = 0; k < 6; k++) row(1, 0);
    check("speed_7hits", speed_a, 0);
    check("speed_b_7hits", speed_b, 1);
    row(1, 0);
    check("speed_8hits", speed_a, 1);
    check("lives_8hits", lives_a, 3);
    for (int k = 0; k < 12; k++) row(1, 0);
    check("speed_20hits", speed_a, 2);
    check("speed_b_sat", speed_b, 1);

    // Missed tile on the edge row.
    wait_state("edge_chk", S_CHECK_INPUT);
    offset = 6'd40; edge_row = 3'b010;
    check_input_done = 1; tick(); check_input_done = 0;
    check("edge_det", cur_a, S_DETECT_EDGE);
    tick();
    check("edge_check", cur_a, S_EDGE_CHECK);
    check("edge_check_go", go_a, G_NONE);
    tick();
    check("edge_fail", cur_a, S_EDGE_FAIL);
    check("edge_fail_go", go_a, G_COL);
    check("edge_fail_lives", lives_a, 2);
    colour_line_done = 1; tick(); colour_line_done = 0;
    check("edge_adv", cur_a, S_EDGE_ADVANCE);
    check("edge_adv_go", go_a, G_EDGE);
    tick();
    check("edge_draw", cur_a, S_DRAW);
    check("edge_draw_go", go_a, G_DRAW);
    offset = '0; edge_row = '0;
    wait_done = 1; tick(); wait_done = 0;
    check("draw_ignore", cur_a, S_DRAW);
    draw_done = 1; tick(); draw_done = 0;
    wait_done = 1; tick(); wait_done = 0;
    check("edge_next", cur_a, S_NEXT_ROW);

    // Cleared edge row: no life lost.
    wait_state("clean_chk", S_CHECK_INPUT);
    offset = 6'd40;
    check_input_done = 1; tick(); check_input_done = 0;
    tick(); tick();
    check("clean_adv", cur_a, S_EDGE_ADVANCE);
    check("clean_lives", lives_a, 2);
    offset = '0; tick();
    check("clean_draw", cur_a, S_DRAW);

    resetn = 0; tick(); resetn = 1;
    check("midrst_state", cur_a, S_IDLE);
    check("midrst_go", go_a, G_NONE);
    check("midrst_lives", lives_a, 3);

    // Three misses end the game.
    startn = 0; tick(); startn = 1;
    reset_screen_done = 1; tick(); reset_screen_done = 0;
    row(0, 1);
    check("inc1_lives", lives_a, 2);
    row(0, 1);
    check("inc2_lives", lives_a, 1);
    wait_state("inc3_chk", S_CHECK_INPUT);
    incorrect = 1; check_input_done = 1; tick();
    incorrect = 0; check_input_done = 0;
    check("inc3_state", cur_a, S_INCORRECT);
    check("inc3_go", go_a, G_INC);
    check("inc3_lives", lives_a, 0);
    incorrect_input_done = 1; tick(); incorrect_input_done = 0;
    check("go_state", cur_a, S_GAME_OVER);
    check("go_flag", gover_a, 1);
    check("go_go", go_a, G_NONE);
    tick();
    check("go_idle", cur_a, S_IDLE);
    tick();
    check("go_sticky", gover_a, 1);
    startn = 0; tick(); startn = 1;
    check("restart_state", cur_a, S_RESET_SCREEN);
    check("restart_gover", gover_a, 0);
    check("restart_lives", lives_a, 3);
    check("restart_speed", speed_a, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
